// File: rtl/kernel_kcore_start_fifo_bcast.sv
// rtl/kernel_kcore_start_fifo_bcast.sv - broadcast start-token FIFO, one writer to NUM_CH readers
module kernel_kcore_start_fifo_bcast #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 2,
  parameter int DEPTH        = 4,
  parameter int NUM_CH       = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               if_full_n,
  input  logic                               if_write_ce,
  input  logic                               if_write,
  input  logic [DATA_WIDTH-1:0]              if_din,
  output logic                               if_almost_full,
  output logic [NUM_CH-1:0]                  if_empty_n,
  input  logic [NUM_CH-1:0]                  if_read_ce,
  input  logic [NUM_CH-1:0]                  if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0]       if_dout,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   if_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         cnt_q [NUM_CH];
  logic [CW-1:0]         cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  afull_q, afull_d;
  logic [CW-1:0]         max_d;
  logic                  wr;
  logic [NUM_CH-1:0]     rd;
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_CH];

  assign wr = if_write & if_write_ce & full_n_q;
  assign rd = if_read & if_read_ce & empty_n_q;

  // Shared token storage: newest at entry 0, oldest falls off the end.
  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Per-channel occupancy next state; the fullest channel drives full/almost-full.
  always_comb begin
    max_d     = '0;
    empty_n_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (wr && !rd[k]) begin
        cnt_d[k] = cnt_q[k] + ONE;
      end else if (rd[k] && !wr) begin
        cnt_d[k] = cnt_q[k] - ONE;
      end
      empty_n_d[k] = (cnt_d[k] != '0);
      if (cnt_d[k] > max_d) begin
        max_d = cnt_d[k];
      end
    end
    full_n_d = (max_d < DEPTH_C);
    afull_d  = (max_d >= THRESH_C);
  end

  // Counter and status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
      empty_n_q <= '0;
      full_n_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      afull_q   <= afull_d;
    end
  end

  // Each channel's oldest unread token sits at index cnt-1.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign rd_addr[k] = (cnt_q[k] == '0) ? '0 : ADDR_WIDTH'(cnt_q[k] - ONE);
    assign if_dout[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[k]];
    assign if_count[k*CW +: CW] = cnt_q[k];
  end

  assign if_full_n      = full_n_q;
  assign if_empty_n     = empty_n_q;
  assign if_almost_full = afull_q;

endmodule

// File: tb/tb_kernel_kcore_start_fifo_bcast.sv
// tb/tb_kernel_kcore_start_fifo_bcast.sv - self-checking bench for the broadcast start FIFO
module tb_kernel_kcore_start_fifo_bcast;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_full_n;
  logic        if_write_ce = 1'b0;
  logic        if_write = 1'b0;
  logic [7:0]  if_din = '0;
  logic        if_almost_full;
  logic [1:0]  if_empty_n;
  logic [1:0]  if_read_ce = '0;
  logic [1:0]  if_read = '0;
  logic [15:0] if_dout;
  logic [5:0]  if_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq0[$];
  logic [7:0] mq1[$];

  wire [7:0] dout0 = if_dout[7:0];
  wire [7:0] dout1 = if_dout[15:8];
  wire [2:0] cnt0  = if_count[2:0];
  wire [2:0] cnt1  = if_count[5:3];

  kernel_kcore_start_fifo_bcast #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .NUM_CH(2), .AFULL_THRESH(3)
  ) dut (
    .clk(clk), .reset(reset), .if_full_n(if_full_n), .if_write_ce(if_write_ce),
    .if_write(if_write), .if_din(if_din), .if_almost_full(if_almost_full),
    .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read),
    .if_dout(if_dout), .if_count(if_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input int n);
    reset = 1'b1;
    if_write = 1'b0;
    if_read = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    mq0.delete();
    mq1.delete();
  endtask

  // One clock of stimulus; the scoreboard queues track what each channel should hold.
  task automatic cycle(input bit w, input logic [7:0] d, input logic [1:0] r);
    bit acc_w, r0, r1;
    acc_w = w && (mq0.size() < 4) && (mq1.size() < 4);
    r0 = r[0] && (mq0.size() > 0);
    r1 = r[1] && (mq1.size() > 0);
    if_write = w;
    if_write_ce = 1'b1;
    if_din = d;
    if_read = r;
    if_read_ce = 2'b11;
    @(posedge clk);
    if (r0) mq0.delete(0);
    if (r1) mq1.delete(0);
    if (acc_w) begin
      mq0.push_back(d);
      mq1.push_back(d);
    end
    #1;
    if_write = 1'b0;
    if_read = '0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %b want 1", if_full_n); end
    checks++; if (if_empty_n !== 2'b00) begin errors++; $display("FAIL reset_empty_n got %b want 00", if_empty_n); end
    checks++; if (if_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", if_almost_full); end
    checks++; if (if_count !== 6'd0) begin errors++; $display("FAIL reset_count got %h want 0", if_count); end
  endtask

  task automatic test_broadcast();
    logic [7:0] exp [2];
    exp[0] = 8'h11;
    exp[1] = 8'h22;
    do_reset(1);
    cycle(1'b1, 8'h11, 2'b00);
    cycle(1'b1, 8'h22, 2'b00);
    checks++; if (cnt0 !== 3'd2 || cnt1 !== 3'd2) begin errors++; $display("FAIL bcast_count got %0d/%0d want 2/2", cnt0, cnt1); end
    checks++; if (dout0 !== 8'h11 || dout1 !== 8'h11) begin errors++; $display("FAIL bcast_dout got %h/%h want 11/11", dout0, dout1); end
    checks++; if (if_empty_n !== 2'b11) begin errors++; $display("FAIL bcast_empty_n got %b want 11", if_empty_n); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dout0 !== mq0[0] || dout0 !== exp[i]) begin
        errors++; $display("FAIL bcast_rd0[%0d] got %h want %h", i, dout0, exp[i]);
      end
      cycle(1'b0, 8'h00, 2'b01);
    end
    checks++; if (if_empty_n !== 2'b10 || cnt0 !== 3'd0) begin errors++; $display("FAIL bcast_ch0_empty got empty_n %b cnt0 %0d want 10/0", if_empty_n, cnt0); end
    checks++; if (cnt1 !== 3'd2 || dout1 !== 8'h11) begin errors++; $display("FAIL bcast_ch1_hold got cnt %0d dout %h want 2/11", cnt1, dout1); end
  endtask

  task automatic test_slow_fill();
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      if (mq0.size() > 0) begin
        checks++;
        if (dout0 !== mq0[0]) begin errors++; $display("FAIL fill_rd0[%0d] got %h want %h", i, dout0, mq0[0]); end
      end
      cycle(1'b1, 8'hA0 + 8'(i), 2'b01);
      checks++;
      if (if_almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, if_almost_full, (i >= 2)); end
      checks++;
      if (if_full_n !== (i < 3)) begin errors++; $display("FAIL fill_full_n[%0d] got %b want %b", i, if_full_n, (i < 3)); end
      checks++;
      if (cnt0 !== 3'(mq0.size()) || cnt1 !== 3'(mq1.size())) begin
        errors++; $display("FAIL fill_count[%0d] got %0d/%0d want %0d/%0d", i, cnt0, cnt1, mq0.size(), mq1.size());
      end
    end
    checks++; if (cnt0 !== 3'd0 || cnt1 !== 3'd4) begin errors++; $display("FAIL fill_final_count got %0d/%0d want 0/4", cnt0, cnt1); end
    checks++; if (dout1 !== 8'hA0) begin errors++; $display("FAIL fill_ch1_head got %h want a0", dout1); end
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hB0;
    checks++; if (dout1 !== mq1[0]) begin errors++; $display("FAIL full_rd1_head got %h want %h", dout1, mq1[0]); end
    cycle(1'b1, 8'hB0, 2'b10);
    checks++; if (cnt1 !== 3'd3 || cnt0 !== 3'd0) begin errors++; $display("FAIL full_drop got %0d/%0d want 0/3", cnt0, cnt1); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL full_recover got %b want 1", if_full_n); end
    cycle(1'b1, 8'hB0, 2'b00);
    checks++; if (cnt1 !== 3'd4 || cnt0 !== 3'd1) begin errors++; $display("FAIL full_accept got %0d/%0d want 1/4", cnt0, cnt1); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout1 !== mq1[0] || dout1 !== exp[i]) begin
        errors++; $display("FAIL full_drain1[%0d] got %h want %h", i, dout1, exp[i]);
      end
      cycle(1'b0, 8'h00, 2'b10);
    end
    checks++; if (if_empty_n !== 2'b01 || dout0 !== 8'hB0) begin errors++; $display("FAIL full_end got empty_n %b dout0 %h want 01/b0", if_empty_n, dout0); end
  endtask

  task automatic test_empty_boundary();
    do_reset(1);
    cycle(1'b1, 8'h55, 2'b01);
    checks++; if (cnt0 !== 3'd1 || cnt1 !== 3'd1) begin errors++; $display("FAIL empty_count got %0d/%0d want 1/1", cnt0, cnt1); end
    checks++; if (dout0 !== 8'h55 || dout0 !== mq0[0]) begin errors++; $display("FAIL empty_dout got %h want 55", dout0); end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      if (mq0.size() > 0) begin
        checks++;
        if (dout0 !== mq0[0] || dout1 !== mq1[0]) begin
          errors++; $display("FAIL b2b_dout[%0d] got %h/%h want %h/%h", i, dout0, dout1, mq0[0], mq1[0]);
        end
      end
      cycle(1'b1, 8'h30 + 8'(i), 2'b11);
      checks++;
      if (if_full_n !== 1'b1 || cnt0 !== 3'd1 || cnt1 !== 3'd1) begin
        errors++; $display("FAIL b2b_state[%0d] got full_n %b cnt %0d/%0d want 1 1/1", i, if_full_n, cnt0, cnt1);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    cycle(1'b1, 8'h01, 2'b00);
    cycle(1'b1, 8'h02, 2'b00);
    cycle(1'b1, 8'h03, 2'b01);
    checks++; if (cnt0 !== 3'd2 || cnt1 !== 3'd3) begin errors++; $display("FAIL mid_pre got %0d/%0d want 2/3", cnt0, cnt1); end
    reset = 1'b1;
    if_write = 1'b1;
    if_write_ce = 1'b1;
    if_din = 8'h99;
    if_read = 2'b11;
    if_read_ce = 2'b11;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if_write = 1'b0;
    if_read = '0;
    mq0.delete();
    mq1.delete();
    checks++;
    if (if_full_n !== 1'b1 || if_empty_n !== 2'b00 || if_almost_full !== 1'b0 || if_count !== 6'd0) begin
      errors++; $display("FAIL mid_reset got full_n %b empty_n %b afull %b count %h want 1 00 0 0", if_full_n, if_empty_n, if_almost_full, if_count);
    end
    cycle(1'b1, 8'h77, 2'b00);
    checks++;
    if (dout0 !== 8'h77 || dout1 !== 8'h77 || cnt0 !== 3'd1 || cnt1 !== 3'd1) begin
      errors++; $display("FAIL mid_after got %h/%h cnt %0d/%0d want 77/77 1/1", dout0, dout1, cnt0, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_slow_fill();
    test_full_boundary();
    test_empty_boundary();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
